// File: rtl/chip8_instr_fetch.sv
// Instruction fetch unit: reads two bytes at the latched PC through a
// synchronous-read memory port and presents the big-endian word with valid/ack.
module chip8_instr_fetch #(
  parameter int ADDR_WIDTH = 12,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  cpu_clk,
  input  logic                  reset_n,
  input  logic                  fetch_start,
  input  logic [ADDR_WIDTH-1:0] PC_readdata,
  input  logic [7:0]            mem_readdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_re,
  output logic [15:0]           instruction,
  output logic                  instr_valid,
  input  logic                  instr_ack,
  output logic                  busy,
  output logic                  addr_wrapped,
  output logic [CNT_WIDTH-1:0]  fetch_count,
  output logic [2:0]            o_dbg_state
);

  // Handshake: instr_valid rises with a new instruction and stays high, with
  // instruction stable, until an edge samples instr_ack=1 in VALID.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH_HI = 3'd1,
    FETCH_LO = 3'd2,
    WAIT_LO  = 3'd3,
    VALID    = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_pc_q;
  logic [7:0]            r_hi;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_mem_re;
  logic [15:0]           r_instruction;
  logic                  r_instr_valid;
  logic                  r_busy;
  logic                  r_addr_wrapped;
  logic [CNT_WIDTH-1:0]  r_fetch_count;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:     if (fetch_start) w_next_state = FETCH_HI;
      FETCH_HI: w_next_state = FETCH_LO;
      FETCH_LO: w_next_state = WAIT_LO;
      WAIT_LO:  w_next_state = VALID;
      VALID:    if (instr_ack) w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  // Memory address/strobe are registered, so they are loaded on the edge that
  // enters the state in which they must be seen by the memory.
  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_pc_q         <= '0;
      r_hi           <= '0;
      r_mem_addr     <= '0;
      r_mem_re       <= 1'b0;
      r_instruction  <= '0;
      r_instr_valid  <= 1'b0;
      r_busy         <= 1'b0;
      r_addr_wrapped <= 1'b0;
      r_fetch_count  <= '0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state != IDLE);
      case (r_state)
        IDLE: begin
          if (fetch_start) begin
            r_pc_q     <= PC_readdata;
            r_mem_addr <= PC_readdata;
            r_mem_re   <= 1'b1;
          end
        end
        FETCH_HI: begin
          r_mem_addr <= r_pc_q + ADDR_ONE;
          r_mem_re   <= 1'b1;
        end
        FETCH_LO: begin
          r_hi       <= mem_readdata;
          r_mem_addr <= '0;
          r_mem_re   <= 1'b0;
        end
        WAIT_LO: begin
          r_instruction  <= {r_hi, mem_readdata};
          r_instr_valid  <= 1'b1;
          r_addr_wrapped <= &r_pc_q;
          if (r_fetch_count != {CNT_WIDTH{1'b1}})
            r_fetch_count <= r_fetch_count + CNT_ONE;
        end
        VALID: begin
          if (instr_ack) r_instr_valid <= 1'b0;
        end
        default: begin
          r_mem_addr <= '0;
          r_mem_re   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr     = r_mem_addr;
  assign mem_re       = r_mem_re;
  assign instruction  = r_instruction;
  assign instr_valid  = r_instr_valid;
  assign busy         = r_busy;
  assign addr_wrapped = r_addr_wrapped;
  assign fetch_count  = r_fetch_count;
  assign o_dbg_state  = r_state;

endmodule

// File: doc/chip8_instr_fetch.md
Name: chip8_instr_fetch

Overview:
- Upstream feeder of Chip8_CPU.
- On request, latches the current PC, reads the two instruction bytes from main memory through a synchronous-read memory port, and assembles them big-endian into a 16-bit instruction.
- Presents the instruction to the CPU with a valid/ack handshake and holds it stable until acknowledged.
- Runs on cpu_clk; the top-level state machine issues fetch_start once per instruction cycle.

Parameters:
- ADDR_WIDTH, 12, memory address width; addresses wrap modulo 2**ADDR_WIDTH.
- CNT_WIDTH, 16, width of the saturating fetch counter.

Ports:
- cpu_clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- fetch_start  in  1  request to fetch at PC_readdata; sampled only in IDLE.
- PC_readdata  in  ADDR_WIDTH  current program counter.
- mem_readdata  in  8  memory read data; valid one cycle after mem_addr/mem_re.
- mem_addr  out  ADDR_WIDTH  memory read address.
- mem_re  out  1  memory read strobe.
- instruction  out  16  assembled instruction {hi,lo}.
- instr_valid  out  1  instruction ready for the CPU.
- instr_ack  in  1  CPU consumed the instruction; sampled only in VALID.
- busy  out  1  high in any state other than IDLE.
- addr_wrapped  out  1  the last fetch wrapped from max address to 0.
- fetch_count  out  CNT_WIDTH  completed fetches, saturating.

Behaviour:
- Reset (async, reset_n=0):
  - State = IDLE.
  - mem_addr = 0, mem_re = 0, instruction = 16'h0000, instr_valid = 0, busy = 0, addr_wrapped = 0, fetch_count = 0.
  - Internal PC latch and hi-byte register = 0.
  - Deassertion mid-fetch abandons the fetch with no partial instruction.
- State machine: IDLE -> FETCH_HI -> FETCH_LO -> WAIT_LO -> VALID -> IDLE. All outputs are registered.
- IDLE:
  - mem_re = 0, mem_addr = 0.
  - When fetch_start=1 at an edge: latch pc_q = PC_readdata, go to FETCH_HI.
  - instr_ack is ignored here.
- FETCH_HI: mem_addr = pc_q, mem_re = 1. Next edge goes to FETCH_LO.
- FETCH_LO:
  - mem_addr = pc_q+1 (ADDR_WIDTH wrap), mem_re = 1.
  - At the next edge capture hi = mem_readdata, go to WAIT_LO.
- WAIT_LO:
  - mem_re = 0, mem_addr = 0.
  - At the next edge: instruction = {hi, mem_readdata}, instr_valid = 1, addr_wrapped = (pc_q == all-ones), fetch_count += 1 (holds at all-ones), go to VALID.
- VALID:
  - instruction and instr_valid are held; busy = 1.
  - When instr_ack=1 at an edge: instr_valid = 0, go to IDLE.
  - instruction keeps its value after ack until the next completed fetch.
- Latency: instr_valid rises on the 4th rising edge counting the edge that sampled fetch_start (3 cycles after FETCH_HI entry). The minimum start-to-start period is 5 cycles with ack given on the first VALID cycle.
- PC_readdata changes after the start sample do not affect the fetch in progress.
- fetch_start while busy is ignored; it is not queued.
- fetch_start and instr_ack together in VALID: ack is taken and the FSM goes to IDLE; start is ignored that cycle.
- instr_ack outside VALID: no effect.
- addr_wrapped is updated only at fetch completion. It is cleared only by reset or by the next non-wrapping completion.

Test Plan:
- Reset, then mem[0x200]=0x61, mem[0x201]=0xF0, PC=0x200, pulse fetch_start -> mem_addr 0x200 then 0x201 with mem_re=1; instruction=0x61F0 and instr_valid=1 on the 4th edge; fetch_count=1; addr_wrapped=0.
- Hold instr_ack=0 for 10 cycles in VALID -> instruction stays 0x61F0 and instr_valid stays 1; ack once -> instr_valid=0 next edge, busy=0, instruction still 0x61F0.
- PC=0xFFF, mem[0xFFF]=0x7E, mem[0x000]=0x54 -> second read address 0x000; instruction=0x7E54; addr_wrapped=1. A following fetch at 0x202 clears addr_wrapped.
- Pulse fetch_start in FETCH_LO and change PC_readdata to 0x300 mid-fetch -> original fetch completes with its latched PC; no second fetch occurs; fetch_count increments by 1.
- Assert reset_n=0 asynchronously during WAIT_LO -> all outputs 0 immediately, with no clock edge needed. After release, a fresh fetch of 0x00E0 completes normally.
- Back-to-back: 5 fetches with ack on the first VALID cycle and start on the first IDLE cycle -> 25 cycles total; fetch_count=5; instructions match memory.
